mastermind_score_seq: RTL

Multi-cycle scoring sequencer for the Mastermind game datapath. On a start pulse it captures a 4-color guess and the secret answer, then walks the positions over a fixed schedule. It produces exact-match (black peg) and color-only-match (white peg) counts and a win flag, and logs each scored guess into a small history buffer for display. It sits between the guess-entry core's CHECK step and the display/feedback logic.

---
 rtl/mastermind_score_seq.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mastermind_score_seq.sv
`default_nettype none
// ============================================================================
// Module   : mastermind_score_seq
// Function : Multi-cycle black/white peg scorer with a small guess history.
// Revision : 1.0 - initial release
// ============================================================================
module mastermind_score_seq #(
    parameter int HIST_DEPTH = 6
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        start,
    input  logic [11:0] guess,
    input  logic [11:0] answer,
    input  logic        clear,
    input  logic [2:0]  hist_rd_idx,
    output logic        busy,
    output logic        score_valid,
    output logic [2:0]  exact_cnt,
    output logic [2:0]  partial_cnt,
    output logic        win,
    output logic [2:0]  hist_count,
    output logic        hist_full,
    output logic [17:0] hist_rd_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXACT   = 2'd1,
        PARTIAL = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [2:0] c_HIST_DEPTH = 3'(HIST_DEPTH);

    state_t      r_state;
    state_t      w_next;
    logic [11:0] r_g;
    logic [11:0] r_a;
    logic [3:0]  r_g_done;
    logic [3:0]  r_a_used;
    logic [3:0]  r_step;
    logic [2:0]  r_exact;
    logic [2:0]  r_partial;
    logic        r_score_valid;
    logic [2:0]  r_exact_cnt;
    logic [2:0]  r_partial_cnt;
    logic        r_win;
    logic [2:0]  r_hist_count;
    logic [17:0] r_hist [HIST_DEPTH];
    logic [17:0] r_hist_rd_data;

    logic        w_exact_hit;
    logic        w_part_hit;
    logic [1:0]  w_i;
    logic [1:0]  w_j;
    logic [2:0]  w_gp;
    logic [2:0]  w_ap;
    logic [2:0]  w_gi;
    logic [2:0]  w_aj;
    logic        w_hist_wr;
    logic [17:0] w_rd_data;

    function automatic logic [2:0] f_color(input logic [11:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    f_color = v[2:0];
            2'd1:    f_color = v[5:3];
            2'd2:    f_color = v[8:6];
            default: f_color = v[11:9];
        endcase
    endfunction

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // In EXACT the low step bits name the position; in PARTIAL step = {i, j}.
    always_comb begin
        w_next      = r_state;
        w_exact_hit = 1'b0;
        w_part_hit  = 1'b0;
        w_i         = r_step[3:2];
        w_j         = r_step[1:0];
        w_gp        = f_color(r_g, r_step[1:0]);
        w_ap        = f_color(r_a, r_step[1:0]);
        w_gi        = f_color(r_g, w_i);
        w_aj        = f_color(r_a, w_j);
        case (r_state)
            IDLE: begin
                if (start) w_next = EXACT;
            end
            EXACT: begin
                w_exact_hit = (w_gp == w_ap) && (w_gp != 3'd0);
                if (r_step[1:0] == 2'd3) w_next = PARTIAL;
            end
            PARTIAL: begin
                w_part_hit = !r_g_done[w_i] && !r_a_used[w_j] &&
                             (w_gi != 3'd0) && (w_gi == w_aj);
                if (r_step == 4'd15) w_next = DONE;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_g           <= '0;
            r_a           <= '0;
            r_g_done      <= '0;
            r_a_used      <= '0;
            r_step        <= '0;
            r_exact       <= '0;
            r_partial     <= '0;
            r_score_valid <= 1'b0;
            r_exact_cnt   <= '0;
            r_partial_cnt <= '0;
            r_win         <= 1'b0;
        end else begin
            r_score_valid <= (r_state == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_g       <= guess;
                        r_a       <= answer;
                        r_g_done  <= '0;
                        r_a_used  <= '0;
                        r_step    <= '0;
                        r_exact   <= '0;
                        r_partial <= '0;
                    end
                end
                EXACT: begin
                    if (w_exact_hit) begin
                        r_g_done[r_step[1:0]] <= 1'b1;
                        r_a_used[r_step[1:0]] <= 1'b1;
                        r_exact               <= r_exact + 3'd1;
                    end
                    r_step <= (r_step[1:0] == 2'd3) ? 4'd0 : r_step + 4'd1;
                end
                PARTIAL: begin
                    if (w_part_hit) begin
                        r_g_done[w_i] <= 1'b1;
                        r_a_used[w_j] <= 1'b1;
                        r_partial     <= r_partial + 3'd1;
                    end
                    r_step <= r_step + 4'd1;
                end
                DONE: begin
                    r_exact_cnt   <= r_exact;
                    r_partial_cnt <= r_partial;
                    r_win         <= (r_exact == 3'd4);
                end
                default: ;
            endcase
        end
    end

    // The result lands in history on the edge that ends the score_valid cycle.
    assign w_hist_wr = r_score_valid && !hist_full && !clear;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_hist_count <= '0;
            for (int e = 0; e < HIST_DEPTH; e++) r_hist[e] <= '0;
        end else if (clear) begin
            r_hist_count <= '0;
            for (int e = 0; e < HIST_DEPTH; e++) r_hist[e] <= '0;
        end else if (w_hist_wr) begin
            r_hist_count <= r_hist_count + 3'd1;
            for (int e = 0; e < HIST_DEPTH; e++) begin
                if (r_hist_count == 3'(e)) r_hist[e] <= {r_g, r_exact_cnt, r_partial_cnt};
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        for (int e = 0; e < HIST_DEPTH; e++) begin
            if ((hist_rd_idx == 3'(e)) && (hist_rd_idx < r_hist_count)) w_rd_data = r_hist[e];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_hist_rd_data <= '0;
        else          r_hist_rd_data <= w_rd_data;
    end

    assign busy         = (r_state != IDLE) || r_score_valid;
    assign score_valid  = r_score_valid;
    assign exact_cnt    = r_exact_cnt;
    assign partial_cnt  = r_partial_cnt;
    assign win          = r_win;
    assign hist_count   = r_hist_count;
    assign hist_full    = (r_hist_count == c_HIST_DEPTH);
    assign hist_rd_data = r_hist_rd_data;

endmodule
`default_nettype wire
